// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg: key codes, sel codes and FSM encoding for calc_key_entry |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [3:0] SEL_ADD = 4'd1;
  localparam logic [3:0] SEL_SUB = 4'd2;
  localparam logic [3:0] SEL_MUL = 4'd3;
  localparam logic [3:0] SEL_DIV = 4'd4;
  localparam logic [3:0] SEL_CLR = 4'd5;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Operator keys 10..13 map onto sel codes 1..4.
  function automatic logic [3:0] key_to_sel(input logic [3:0] key);
    return key - 4'd9;
  endfunction
endpackage
`default_nettype wire

// File: rtl/calc_key_entry_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_key_entry_if: key strobe input and calculator operand outputs |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface calc_key_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] sel;
  logic       go;
  logic       err;

  modport master (
    input  key_valid, key_code,
    output op_a, op_b, sel, go, err
  );

  modport slave (
    output key_valid, key_code,
    input  op_a, op_b, sel, go, err
  );
endinterface
`default_nettype wire

// File: rtl/calc_key_entry_digit_acc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_digit_acc: decimal shift-in of one digit with overflow check  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module calc_digit_acc #(
  parameter int MAX_DIGITS = 2,
  parameter int CNT_W      = 2
) (
  input  logic [3:0]       acc,
  input  logic [CNT_W-1:0] cnt,
  input  logic [3:0]       digit,
  output logic [3:0]       acc_next,
  output logic             ovf
);
  logic [7:0] sum;

  always_comb begin
    sum      = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {4'd0, digit};
    acc_next = sum[3:0];
    ovf      = (sum > 8'd15) || (32'(cnt) >= MAX_DIGITS);
  end
endmodule
`default_nettype wire

// File: rtl/calc_key_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_key_entry: keypad strobes to calculator operands and sel      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 2
) (
  input logic                 clk,
  input logic                 rst,
  calc_key_entry_if.master    bus
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_t           state;
  logic [3:0]       acc_a, acc_b, pend_op;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_a_r, op_b_r, sel_r;
  logic             go_r, err_r;

  logic [3:0]       acc_in, acc_next;
  logic [CNT_W-1:0] cnt_in;
  logic             ovf, is_digit, is_op;

  assign is_digit = (bus.key_code <= 4'd9);
  assign is_op    = (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_DIV);

  // Digits arriving in S_OP/S_DONE begin a fresh operand, so feed zeros.
  always_comb begin
    acc_in = 4'd0;
    cnt_in = '0;
    if (state == S_A) begin
      acc_in = acc_a;
      cnt_in = cnt;
    end else if (state == S_B) begin
      acc_in = acc_b;
      cnt_in = cnt;
    end
  end

  calc_digit_acc #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_digit_acc (
    .acc      (acc_in),
    .cnt      (cnt_in),
    .digit    (bus.key_code),
    .acc_next (acc_next),
    .ovf      (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_A;
      acc_a   <= 4'd0;
      acc_b   <= 4'd0;
      cnt     <= '0;
      pend_op <= 4'd0;
      op_a_r  <= 4'd0;
      op_b_r  <= 4'd0;
      sel_r   <= SEL_CLR;
      go_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      go_r <= 1'b0;
      if (bus.key_valid) begin
        if (bus.key_code == KEY_CLR) begin
          state   <= S_A;
          acc_a   <= 4'd0;
          acc_b   <= 4'd0;
          cnt     <= '0;
          pend_op <= 4'd0;
          op_a_r  <= 4'd0;
          op_b_r  <= 4'd0;
          sel_r   <= SEL_CLR;
          err_r   <= 1'b0;
        end else begin
          case (state)
            S_A: begin
              if (is_digit) begin
                if (ovf) begin
                  state <= S_ERR;
                  sel_r <= SEL_CLR;
                  err_r <= 1'b1;
                end else begin
                  acc_a <= acc_next;
                  cnt   <= cnt + 1'b1;
                end
              end else if (is_op) begin
                pend_op <= key_to_sel(bus.key_code);
                state   <= S_OP;
              end
            end
            S_OP: begin
              if (is_digit) begin
                acc_b <= acc_next;
                cnt   <= CNT_W'(1);
                state <= S_B;
              end else if (is_op) begin
                pend_op <= key_to_sel(bus.key_code);
              end
            end
            S_B: begin
              if (is_digit) begin
                if (ovf) begin
                  state <= S_ERR;
                  sel_r <= SEL_CLR;
                  err_r <= 1'b1;
                end else begin
                  acc_b <= acc_next;
                  cnt   <= cnt + 1'b1;
                end
              end else if (bus.key_code == KEY_EQ) begin
                if (pend_op == SEL_DIV && acc_b == 4'd0) begin
                  state <= S_ERR;
                  sel_r <= SEL_CLR;
                  err_r <= 1'b1;
                end else begin
                  op_a_r <= acc_a;
                  op_b_r <= acc_b;
                  sel_r  <= pend_op;
                  go_r   <= 1'b1;
                  state  <= S_DONE;
                end
              end
            end
            S_DONE: begin
              if (is_digit) begin
                acc_a <= acc_next;
                cnt   <= CNT_W'(1);
                sel_r <= SEL_CLR;
                state <= S_A;
              end
            end
            S_ERR: begin
            end
            default: state <= S_A;
          endcase
        end
      end
    end
  end

  assign bus.op_a = op_a_r;
  assign bus.op_b = op_b_r;
  assign bus.sel  = sel_r;
  assign bus.go   = go_r;
  assign bus.err  = err_r;
endmodule
`default_nettype wire

// File: tb/tb_calc_key_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_calc_key_entry: directed keys with a go-driven scoreboard       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_calc_key_entry;
  import calc_pkg::*;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  calc_key_entry_if bus();

  calc_key_entry #(.MAX_DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic eq_commit(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    exp_t e;
    e.a = a; e.b = b; e.s = s;
    q.push_back(e);
    press(KEY_EQ);
    chk("go_latency", 8'(bus.go), 8'd1);
  endtask

  // Monitor: every go pulse pops one expected commit.
  initial begin
    bit   prev_go;
    exp_t e;
    prev_go = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_go = 1'b0;
      end else begin
        if (bus.go) begin
          checks++;
          if (prev_go) begin
            failures++;
            $display("FAIL go_width: go high in consecutive cycles, required one cycle");
          end else if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_go: op_a=%0d op_b=%0d sel=%0d, required no go",
                     bus.op_a, bus.op_b, bus.sel);
          end else begin
            e = q.pop_front();
            if (bus.op_a !== e.a || bus.op_b !== e.b || bus.sel !== e.s) begin
              failures++;
              $display("FAIL commit: actual a=%0d b=%0d sel=%0d required a=%0d b=%0d sel=%0d",
                       bus.op_a, bus.op_b, bus.sel, e.a, e.b, e.s);
            end
          end
        end
        prev_go = bus.go;
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_op_a", 8'(bus.op_a), 8'd0);
    chk("rst_op_b", 8'(bus.op_b), 8'd0);
    chk("rst_sel",  8'(bus.sel),  8'd5);
    chk("rst_go",   8'(bus.go),   8'd0);
    chk("rst_err",  8'(bus.err),  8'd0);
    rst = 1'b0;

    // 12 + 3
    press(4'd1); press(4'd2); press(KEY_ADD); press(4'd3);
    eq_commit(4'd12, 4'd3, SEL_ADD);
    chk("add_err", 8'(bus.err), 8'd0);

    // 9 / 0 -> error, then clear
    press(4'd9); press(KEY_DIV); press(4'd0); press(KEY_EQ);
    chk("div0_err",  8'(bus.err),  8'd1);
    chk("div0_sel",  8'(bus.sel),  8'd5);
    chk("div0_op_a", 8'(bus.op_a), 8'd12);
    press(KEY_CLR);
    chk("clr_err",  8'(bus.err),  8'd0);
    chk("clr_sel",  8'(bus.sel),  8'd5);
    chk("clr_op_a", 8'(bus.op_a), 8'd0);
    chk("clr_op_b", 8'(bus.op_b), 8'd0);

    // 16 overflows, three digits overflow
    press(4'd1);
    chk("ovf16_first", 8'(bus.err), 8'd0);
    press(4'd6);
    chk("ovf16_err", 8'(bus.err), 8'd1);
    press(KEY_CLR);
    press(4'd0); press(4'd0);
    chk("lead0_ok", 8'(bus.err), 8'd0);
    press(4'd7);
    chk("digits_err", 8'(bus.err), 8'd1);
    press(KEY_CLR);

    // Operator replacement; outputs held during entry
    press(4'd5); press(KEY_ADD); press(KEY_SUB); press(KEY_MUL); press(4'd4);
    chk("hold_op_a", 8'(bus.op_a), 8'd0);
    chk("hold_sel",  8'(bus.sel),  8'd5);
    eq_commit(4'd5, 4'd4, SEL_MUL);

    // New A after commit
    press(4'd7);
    chk("newa_sel",  8'(bus.sel),  8'd5);
    chk("newa_op_a", 8'(bus.op_a), 8'd5);
    press(KEY_MUL); press(4'd2);
    eq_commit(4'd7, 4'd2, SEL_MUL);

    // Boundary 15 with leading-zero B
    press(4'd1); press(4'd5); press(KEY_SUB); press(4'd0); press(4'd7);
    eq_commit(4'd15, 4'd7, SEL_SUB);
    chk("max15_err", 8'(bus.err), 8'd0);

    // EQ in S_A ignored, real divide
    press(4'd8); press(KEY_EQ); press(KEY_DIV); press(4'd2);
    eq_commit(4'd8, 4'd2, SEL_DIV);

    // Asynchronous reset mid-entry
    press(4'd1); press(KEY_ADD);
    #2 rst = 1'b1;
    #1;
    chk("arst_op_a", 8'(bus.op_a), 8'd0);
    chk("arst_op_b", 8'(bus.op_b), 8'd0);
    chk("arst_sel",  8'(bus.sel),  8'd5);
    #1 rst = 1'b0;
    press(4'd2); press(KEY_SUB); press(4'd1);
    eq_commit(4'd2, 4'd1, SEL_SUB);

    repeat (4) @(negedge clk);
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
